pipe_ctrl: RTL and testbench



---
 rtl/legv8_pkg.sv | 13 +
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/hazard_detect.sv | 15 +
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 pipeline control logic.
package legv8_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its hazard controller.
// The controller side is the master: it receives hazard information and
// drives the register enables and flushes.
interface pipe_ctrl_if;
  import legv8_pkg::*;

  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memread;
  logic             mem_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic en_pc;
  logic en_ifid;
  logic en_idex;
  logic en_exmem;
  logic en_memwb;
  logic flush_ifid;
  logic flush_idex;
  logic flush_exmem;

  modport master (
    input  id_rn, id_rm, ex_rd, ex_memread, mem_branch_taken, mem_req, mem_ready,
    output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
    output flush_ifid, flush_idex, flush_exmem
  );

  modport slave (
    output id_rn, id_rm, ex_rd, ex_memread, mem_branch_taken, mem_req, mem_ready,
    input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
    input  flush_ifid, flush_idex, flush_exmem
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the instruction in
// ID reads. XZR is hardwired zero, so it never creates a dependency.
module hazard_detect
  import legv8_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  output logic             lu
);

  assign lu = ex_memread && (ex_rd != XZR) && ((ex_rd == id_rn) || (ex_rd == id_rm));

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage LEGv8 pipeline.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal flow; load-use bubbles and branch flushes applied
//   MEM_WAIT | multi-cycle data access outstanding, whole pipe frozen
//   ERROR    | memory watchdog expired, pipe frozen until reset
//
// A branch that resolves in the same cycle a memory stall starts is
// remembered in pend_flush and applied when the access completes.
module pipe_ctrl
  import legv8_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_ctrl_if.master      pif,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err
);

  localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  ctrl_state_t       fsm;
  logic              pend_flush;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;

  logic lu;
  logic stall_mem;
  logic take_flush;
  logic en_front;
  logic en_back;
  logic fl_all;
  logic fl_idex;

  hazard_detect u_hazard (
    .ex_memread (pif.ex_memread),
    .ex_rd      (pif.ex_rd),
    .id_rn      (pif.id_rn),
    .id_rm      (pif.id_rm),
    .lu         (lu)
  );

  assign wait_nxt = wait_cnt + WAIT_W'(1);

  // Output mux: memory freeze beats branch flush beats load-use bubble.
  always_comb begin
    stall_mem  = 1'b0;
    take_flush = 1'b0;
    en_front   = 1'b0;
    en_back    = 1'b0;
    fl_all     = 1'b0;
    fl_idex    = 1'b0;
    case (fsm)
      RUN: begin
        stall_mem  = pif.mem_req && !pif.mem_ready;
        take_flush = pif.mem_branch_taken;
      end
      MEM_WAIT: begin
        stall_mem  = !pif.mem_ready;
        take_flush = pif.mem_branch_taken || pend_flush;
      end
      default: stall_mem = 1'b1;
    endcase
    if (!reset || stall_mem) begin
      en_front = 1'b0;
      en_back  = 1'b0;
    end else if (take_flush) begin
      en_front = 1'b1;
      en_back  = 1'b1;
      fl_all   = 1'b1;
    end else if (lu) begin
      en_back  = 1'b1;
      fl_idex  = 1'b1;
    end else begin
      en_front = 1'b1;
      en_back  = 1'b1;
    end
  end

  assign pif.en_pc       = en_front;
  assign pif.en_ifid     = en_front;
  assign pif.en_idex     = en_back;
  assign pif.en_exmem    = en_back;
  assign pif.en_memwb    = en_back;
  assign pif.flush_ifid  = fl_all;
  assign pif.flush_idex  = fl_all || fl_idex;
  assign pif.flush_exmem = fl_all;

  // Sequencing FSM, memory watchdog and saturating stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm        <= RUN;
      pend_flush <= 1'b0;
      wait_cnt   <= '0;
      stall_cnt  <= '0;
      err        <= 1'b0;
    end else begin
      if (!(en_front && en_back) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      case (fsm)
        RUN: begin
          if (pif.mem_req && !pif.mem_ready) begin
            fsm        <= MEM_WAIT;
            wait_cnt   <= WAIT_W'(1);
            pend_flush <= pif.mem_branch_taken;
          end
        end
        MEM_WAIT: begin
          if (pif.mem_ready) begin
            fsm        <= RUN;
            wait_cnt   <= '0;
            pend_flush <= 1'b0;
          end else begin
            wait_cnt <= wait_nxt;
            if (32'(wait_nxt) >= 32'(TIMEOUT)) begin
              fsm <= ERROR;
              err <= 1'b1;
            end
          end
        end
        default: err <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with fixed expectations, then a
// randomized run checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int T_OUT = 8;
  localparam int CW    = 5;
  localparam int SMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] stall_cnt;
  logic          err;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_if pif ();

  pipe_ctrl #(.TIMEOUT(T_OUT), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .pif       (pif),
    .stall_cnt (stall_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  wire [4:0] en_v = {pif.en_pc, pif.en_ifid, pif.en_idex, pif.en_exmem, pif.en_memwb};
  wire [2:0] fl_v = {pif.flush_ifid, pif.flush_idex, pif.flush_exmem};

  // Behavioural model state: waiting on memory, dead, branch remembered,
  // cycles waited so far, stall cycles seen.
  bit       m_wait, m_err, m_pend;
  int       m_wcnt, m_scnt;
  logic [4:0] x_en;
  logic [2:0] x_fl;

  task automatic set_in(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                        input logic lr, input logic br, input logic rq, input logic rdy);
    pif.id_rn = rn; pif.id_rm = rm; pif.ex_rd = rd;
    pif.ex_memread = lr; pif.mem_branch_taken = br;
    pif.mem_req = rq; pif.mem_ready = rdy;
  endtask

  task automatic idle();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Expected outputs for the present inputs and model state.
  task automatic model_eval();
    bit hz, frozen, flush;
    if (!reset) begin
      m_wait = 0; m_err = 0; m_pend = 0; m_wcnt = 0; m_scnt = 0;
      x_en = 5'b0; x_fl = 3'b0;
      return;
    end
    hz = pif.ex_memread && (pif.ex_rd != 5'd31) &&
         (pif.ex_rd == pif.id_rn || pif.ex_rd == pif.id_rm);
    if (m_err)       frozen = 1;
    else if (m_wait) frozen = !pif.mem_ready;
    else             frozen = pif.mem_req && !pif.mem_ready;
    flush = pif.mem_branch_taken || (m_wait && m_pend);
    if (frozen)     begin x_en = 5'b00000; x_fl = 3'b000; end
    else if (flush) begin x_en = 5'b11111; x_fl = 3'b111; end
    else if (hz)    begin x_en = 5'b00111; x_fl = 3'b010; end
    else            begin x_en = 5'b11111; x_fl = 3'b000; end
  endtask

  task automatic model_step();
    if (!reset) begin
      m_wait = 0; m_err = 0; m_pend = 0; m_wcnt = 0; m_scnt = 0;
      return;
    end
    if (x_en != 5'b11111 && m_scnt < SMAX) m_scnt++;
    if (m_err) begin
    end else if (m_wait) begin
      if (pif.mem_ready) begin
        m_wait = 0; m_pend = 0; m_wcnt = 0;
      end else begin
        m_wcnt++;
        if (m_wcnt >= T_OUT) begin m_err = 1; m_wait = 0; end
      end
    end else if (pif.mem_req && !pif.mem_ready) begin
      m_wait = 1; m_wcnt = 1; m_pend = pif.mem_branch_taken;
    end
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (en_v !== 5'b0) begin errors++; $display("FAIL reset_en cyc%0d: got %b want 00000", i, en_v); end
      checks++; if (fl_v !== 3'b0) begin errors++; $display("FAIL reset_flush cyc%0d: got %b want 000", i, fl_v); end
      checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt cyc%0d: got %0d want 0", i, stall_cnt); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err cyc%0d: got %b want 0", i, err); end
      tick();
    end
    reset = 1'b1;
    idle();
    #1;
    checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL release_en: got %b want 11111", en_v); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (en_v !== 5'b00111) begin errors++; $display("FAIL lu_en: got %b want 00111", en_v); end
    checks++; if (fl_v !== 3'b010) begin errors++; $display("FAIL lu_flush: got %b want 010", fl_v); end
    tick(); idle(); #1;
    checks++; if (stall_cnt !== 5'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    set_in(5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL xzr_en: got %b want 11111", en_v); end
    checks++; if (fl_v !== 3'b000) begin errors++; $display("FAIL xzr_flush: got %b want 000", fl_v); end
    tick(); idle(); #1;
    checks++; if (stall_cnt !== 5'd1) begin errors++; $display("FAIL xzr_cnt: got %0d want 1", stall_cnt); end
    set_in(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (en_v !== 5'b00111) begin errors++; $display("FAIL lu_rm_en: got %b want 00111", en_v); end
    tick();
    set_in(5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL noload_en: got %b want 11111", en_v); end
    tick(); idle(); #1;
    checks++; if (stall_cnt !== 5'd2) begin errors++; $display("FAIL lu_rm_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    set_in(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1); #1;
    checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL br_en: got %b want 11111", en_v); end
    checks++; if (fl_v !== 3'b111) begin errors++; $display("FAIL br_flush: got %b want 111", fl_v); end
    tick();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL single_access_en: got %b want 11111", en_v); end
    tick(); idle(); #1;
    checks++; if (stall_cnt !== 5'd0) begin errors++; $display("FAIL br_cnt: got %0d want 0", stall_cnt); end
    checks++; if (fl_v !== 3'b000) begin errors++; $display("FAIL br_after_flush: got %b want 000", fl_v); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0); #1;
      checks++; if (en_v !== 5'b00000) begin errors++; $display("FAIL wait_en cyc%0d: got %b want 00000", i, en_v); end
      checks++; if (fl_v !== 3'b000) begin errors++; $display("FAIL wait_flush cyc%0d: got %b want 000", i, fl_v); end
      tick();
    end
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL wait_done_en: got %b want 11111", en_v); end
    checks++; if (fl_v !== 3'b000) begin errors++; $display("FAIL wait_done_flush: got %b want 000", fl_v); end
    tick();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    checks++; if (stall_cnt !== 5'd4) begin errors++; $display("FAIL wait_cnt: got %0d want 4", stall_cnt); end
    checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL wait_back_run: got %b want 11111", en_v); end
    tick();
  endtask

  task automatic test_pend_flush();
    do_reset();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0); #1;
    checks++; if (en_v !== 5'b00000) begin errors++; $display("FAIL pend_c0_en: got %b want 00000", en_v); end
    checks++; if (fl_v !== 3'b000) begin errors++; $display("FAIL pend_c0_flush: got %b want 000", fl_v); end
    tick();
    for (int i = 1; i < 3; i++) begin
      set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0); #1;
      checks++; if (fl_v !== 3'b000) begin errors++; $display("FAIL pend_c%0d_flush: got %b want 000", i, fl_v); end
      tick();
    end
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    checks++; if (fl_v !== 3'b111) begin errors++; $display("FAIL pend_c3_flush: got %b want 111", fl_v); end
    checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL pend_c3_en: got %b want 11111", en_v); end
    tick(); idle(); #1;
    checks++; if (fl_v !== 3'b000) begin errors++; $display("FAIL pend_c4_flush: got %b want 000", fl_v); end
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < T_OUT; i++) begin
      set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0); #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_early_err cyc%0d: got %b want 0", i, err); end
      tick();
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err: got %b want 1", err); end
    for (int i = 0; i < 3; i++) begin
      set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1); #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_sticky cyc%0d: got %b want 1", i, err); end
      checks++; if (en_v !== 5'b00000) begin errors++; $display("FAIL wd_frozen cyc%0d: got %b want 00000", i, en_v); end
      tick();
    end
    reset = 1'b0; #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_clear_err: got %b want 0", err); end
    checks++; if (stall_cnt !== 5'd0) begin errors++; $display("FAIL wd_clear_cnt: got %0d want 0", stall_cnt); end
    tick();
    reset = 1'b1;
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL wd_run_en: got %b want 11111", en_v); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    #2 reset = 1'b0; #1;
    checks++; if (en_v !== 5'b00000) begin errors++; $display("FAIL midrst_en: got %b want 00000", en_v); end
    tick();
    reset = 1'b1;
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    checks++; if (fl_v !== 3'b000) begin errors++; $display("FAIL midrst_pend_lost: got %b want 000", fl_v); end
    tick();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL midrst_run: got %b want 11111", en_v); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (SMAX + 10) tick();
    checks++; if (stall_cnt !== 5'(SMAX)) begin errors++; $display("FAIL sat_cnt: got %0d want %0d", stall_cnt, SMAX); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sat_err: got %b want 1", err); end
  endtask

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 3);
    return (r == 3) ? 5'd31 : 5'(r + 4);
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in(rnd_reg(), rnd_reg(), rnd_reg(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 3) != 0));
      reset = (m_err && $urandom_range(0, 3) == 0) ? 1'b0 : 1'($urandom_range(0, 59) != 0);
      #1;
      model_eval();
      checks++; if (en_v !== x_en) begin errors++; $display("FAIL rnd_en it%0d: got %b want %b", i, en_v, x_en); end
      checks++; if (fl_v !== x_fl) begin errors++; $display("FAIL rnd_flush it%0d: got %b want %b", i, fl_v, x_fl); end
      checks++; if (stall_cnt !== 5'(m_scnt)) begin errors++; $display("FAIL rnd_cnt it%0d: got %0d want %0d", i, stall_cnt, m_scnt); end
      checks++; if (err !== 1'(m_err)) begin errors++; $display("FAIL rnd_err it%0d: got %b want %b", i, err, m_err); end
      tick();
    end
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle();
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_pend_flush();
    test_watchdog();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
